// File: rtl/alu_operand_fetch_pkg.sv
// Shared definitions for the ALU operand-fetch stage: widths, instruction
// field positions and the ALU select encodings.
package alu_operand_fetch_pkg;

    localparam int DATA_W = 16;
    localparam int REG_N  = 8;
    localparam int ADDR_W = 3;
    localparam int SEL_W  = 3;
    localparam int IMM_W  = 3;

    localparam int SEL_MSB    = 15;
    localparam int SEL_LSB    = 13;
    localparam int RD_MSB     = 12;
    localparam int RD_LSB     = 10;
    localparam int RS_MSB     = 9;
    localparam int RS_LSB     = 7;
    localparam int RT_MSB     = 6;
    localparam int RT_LSB     = 4;
    localparam int IMM_EN_BIT = 3;
    localparam int IMM_MSB    = 2;
    localparam int IMM_LSB    = 0;

    typedef enum logic [SEL_W-1:0] {
        ALU_ADD   = 3'b000,
        ALU_SUB   = 3'b001,
        ALU_AND   = 3'b010,
        ALU_OR    = 3'b011,
        ALU_XOR   = 3'b100,
        ALU_PASSB = 3'b101
    } alu_sel_e;

    // Immediates are always zero-extended to the operand width.
    function automatic logic [DATA_W-1:0] zext_imm(input logic [IMM_W-1:0] imm);
        return {{(DATA_W-IMM_W){1'b0}}, imm};
    endfunction

endpackage

// File: rtl/alu_operand_fetch_regfile_2r1w.sv
// 8x16 register file with two combinational read ports and one write port;
// r0 is hard-wired to zero. No bypass here.
module regfile_2r1w
    import alu_operand_fetch_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr_a,
    output logic [DATA_W-1:0] rd_data_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_b
);

    logic [DATA_W-1:0] mem_r [REG_N];
    logic              wr_ok_s;

    assign wr_ok_s = wr_en && (wr_addr != {ADDR_W{1'b0}});

    // Array storage: cleared on reset, single write port otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < REG_N; i++) begin
                mem_r[i] <= {DATA_W{1'b0}};
            end
        end else if (wr_ok_s) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    assign rd_data_a = (rd_addr_a == {ADDR_W{1'b0}}) ? {DATA_W{1'b0}} : mem_r[rd_addr_a];
    assign rd_data_b = (rd_addr_b == {ADDR_W{1'b0}}) ? {DATA_W{1'b0}} : mem_r[rd_addr_b];

endmodule

// File: rtl/alu_operand_fetch.sv
// Operand-fetch stage feeding the ALU: decodes the instruction, reads the
// register file with write-back bypass and holds the operation under a
// valid/ready handshake.
module alu_operand_fetch
    import alu_operand_fetch_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [15:0]       instr,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] A,
    output logic [DATA_W-1:0] B,
    output logic [SEL_W-1:0]  select,
    output logic [ADDR_W-1:0] dest
);

    logic [SEL_W-1:0]  sel_s;
    logic [ADDR_W-1:0] rd_s;
    logic [ADDR_W-1:0] rs_s;
    logic [ADDR_W-1:0] rt_s;
    logic              imm_en_s;
    logic [IMM_W-1:0]  imm_s;

    logic [DATA_W-1:0] rs_data_s;
    logic [DATA_W-1:0] rt_data_s;
    logic              wb_live_s;
    logic              accept_s;
    logic [DATA_W-1:0] op_a_s;
    logic [DATA_W-1:0] op_b_s;

    logic              out_valid_r;
    logic [DATA_W-1:0] a_r;
    logic [DATA_W-1:0] b_r;
    logic [SEL_W-1:0]  sel_r;
    logic [ADDR_W-1:0] dest_r;

    assign sel_s    = instr[SEL_MSB:SEL_LSB];
    assign rd_s     = instr[RD_MSB:RD_LSB];
    assign rs_s     = instr[RS_MSB:RS_LSB];
    assign rt_s     = instr[RT_MSB:RT_LSB];
    assign imm_en_s = instr[IMM_EN_BIT];
    assign imm_s    = instr[IMM_MSB:IMM_LSB];

    regfile_2r1w u_regfile (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wb_en),
        .wr_addr   (wb_addr),
        .wr_data   (wb_data),
        .rd_addr_a (rs_s),
        .rd_data_a (rs_data_s),
        .rd_addr_b (rt_s),
        .rd_data_b (rt_data_s)
    );

    // The array only updates on the edge, so a same-cycle write is forwarded.
    assign wb_live_s = wb_en && (wb_addr != {ADDR_W{1'b0}});
    assign in_ready  = !out_valid_r || out_ready;
    assign accept_s  = in_valid && in_ready;

    // Operand selection: bypass for both sources, immediate overrides rt.
    always_comb begin
        op_a_s = rs_data_s;
        op_b_s = rt_data_s;
        if (wb_live_s && (wb_addr == rs_s)) begin
            op_a_s = wb_data;
        end else begin
            op_a_s = rs_data_s;
        end
        if (imm_en_s) begin
            op_b_s = zext_imm(imm_s);
        end else if (wb_live_s && (wb_addr == rt_s)) begin
            op_b_s = wb_data;
        end else begin
            op_b_s = rt_data_s;
        end
    end

    // Output register: loads on accept, drops valid on drain, holds on stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_r <= 1'b0;
            a_r         <= {DATA_W{1'b0}};
            b_r         <= {DATA_W{1'b0}};
            sel_r       <= {SEL_W{1'b0}};
            dest_r      <= {ADDR_W{1'b0}};
        end else if (accept_s) begin
            out_valid_r <= 1'b1;
            a_r         <= op_a_s;
            b_r         <= op_b_s;
            sel_r       <= sel_s;
            dest_r      <= rd_s;
        end else if (out_ready) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    assign out_valid = out_valid_r;
    assign A         = a_r;
    assign B         = b_r;
    assign select    = sel_r;
    assign dest      = dest_r;

endmodule
